// File: rtl/pipe_pkg.sv
// Shared definitions for the reusable pipeline stage register.
// Holds the occupancy state encoding and the default bubble control word.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_e;

    localparam int unsigned CTRL_W_DEF = 16;
    localparam int unsigned DATA_W_DEF = 96;

    // All enables de-asserted: safe to present downstream at any time.
    localparam logic [CTRL_W_DEF-1:0] CTRL_BUBBLE_DEF = '0;

endpackage

// File: rtl/pipe_entry.sv
// One stage entry: valid flag, control word and data word.
// Clear empties the entry and parks ctrl at the bubble; data is kept.
module pipe_entry #(
    parameter int unsigned        CTRL_W      = 16,
    parameter int unsigned        DATA_W      = 96,
    parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = '0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_valid <= 1'b0;
            r_ctrl  <= CTRL_BUBBLE;
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_ctrl  <= CTRL_BUBBLE;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_ctrl  <= i_ctrl;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_ctrl  = r_ctrl;
    assign o_data  = r_data;

endmodule

// File: rtl/pipeline_stage_reg.sv
// Reusable pipeline stage register with a 2-entry skid buffer.
// Main entry M drives the outputs; skid entry S absorbs one stall.
module pipeline_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       CTRL_W      = CTRL_W_DEF,
    parameter int unsigned       DATA_W      = DATA_W_DEF,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = CTRL_W'(CTRL_BUBBLE_DEF)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    pipe_state_e r_state;
    pipe_state_e w_state_nxt;

    logic              w_in_xfer;
    logic              w_out_xfer;
    logic              w_m_load;
    logic              w_m_clear;
    logic              w_m_from_s;
    logic              w_s_load;
    logic              w_s_clear;
    logic [CTRL_W-1:0] w_m_ctrl_in;
    logic [DATA_W-1:0] w_m_data_in;
    logic              w_m_valid;
    logic              w_s_valid;
    logic [CTRL_W-1:0] w_m_ctrl;
    logic [DATA_W-1:0] w_m_data;
    logic [CTRL_W-1:0] w_s_ctrl;
    logic [DATA_W-1:0] w_s_data;

    assign in_ready   = (r_state != ST_TWO);
    assign out_valid  = (r_state != ST_EMPTY);
    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = out_valid & out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_m_load    = 1'b0;
        w_m_clear   = 1'b0;
        w_m_from_s  = 1'b0;
        w_s_load    = 1'b0;
        w_s_clear   = 1'b0;
        if (flush) begin
            // Same-cycle input is dropped even if the producer saw ready.
            w_state_nxt = ST_EMPTY;
            w_m_clear   = 1'b1;
            w_s_clear   = 1'b1;
        end else begin
            unique case (r_state)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        w_m_load    = 1'b1;
                        w_state_nxt = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_in_xfer && w_out_xfer) begin
                        w_m_load = 1'b1;
                    end else if (w_in_xfer) begin
                        w_s_load    = 1'b1;
                        w_state_nxt = ST_TWO;
                    end else if (w_out_xfer) begin
                        w_m_clear   = 1'b1;
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_out_xfer) begin
                        w_m_load    = 1'b1;
                        w_m_from_s  = 1'b1;
                        w_s_clear   = 1'b1;
                        w_state_nxt = ST_ONE;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                    w_m_clear   = 1'b1;
                    w_s_clear   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // M refills from S so the older entry always leaves first.
    assign w_m_ctrl_in = w_m_from_s ? w_s_ctrl : in_ctrl;
    assign w_m_data_in = w_m_from_s ? w_s_data : in_data;

    pipe_entry #(
        .CTRL_W      (CTRL_W),
        .DATA_W      (DATA_W),
        .CTRL_BUBBLE (CTRL_BUBBLE)
    ) u_main (
        .Clk     (Clk),
        .Reset   (Reset),
        .i_load  (w_m_load),
        .i_clear (w_m_clear),
        .i_ctrl  (w_m_ctrl_in),
        .i_data  (w_m_data_in),
        .o_valid (w_m_valid),
        .o_ctrl  (w_m_ctrl),
        .o_data  (w_m_data)
    );

    pipe_entry #(
        .CTRL_W      (CTRL_W),
        .DATA_W      (DATA_W),
        .CTRL_BUBBLE (CTRL_BUBBLE)
    ) u_skid (
        .Clk     (Clk),
        .Reset   (Reset),
        .i_load  (w_s_load),
        .i_clear (w_s_clear),
        .i_ctrl  (in_ctrl),
        .i_data  (in_data),
        .o_valid (w_s_valid),
        .o_ctrl  (w_s_ctrl),
        .o_data  (w_s_data)
    );

    assign out_ctrl  = w_m_ctrl;
    assign out_data  = w_m_data;
    assign occupancy = {1'b0, w_m_valid} + {1'b0, w_s_valid};

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Bench for pipeline_stage_reg: directed cases plus random traffic
// checked every cycle against a queue-based reference model.
module tb_pipeline_stage_reg;

    typedef struct packed {
        logic [15:0] c;
        logic [95:0] d;
    } ent_t;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_ctrl = '0;
    logic [95:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_ctrl;
    logic [95:0] out_data;
    logic [1:0]  occupancy;

    int n_vec = 0;
    int n_err = 0;

    ent_t        q[$];
    logic [95:0] m_data = '0;
    bit          armed = 1'b0;

    pipeline_stage_reg dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [95:0] mkd(input logic [15:0] k);
        return {16'hDEAD, k, 64'h0123_4567_89AB_CDEF ^ {48'h0, k}};
    endfunction

    // Reference: a FIFO of at most two entries, emptied by flush/reset.
    always @(posedge Clk) begin
        bit was_empty;
        bit ix;
        bit ox;
        if (Reset) begin
            q.delete();
            m_data = '0;
            armed  = 1'b1;
        end else if (flush) begin
            q.delete();
        end else begin
            was_empty = (q.size() == 0);
            ox = !was_empty && out_ready;
            ix = in_valid && (q.size() < 2);
            if (ox) void'(q.pop_front());
            if (ix) q.push_back({in_ctrl, in_data});
            if ((ox || was_empty) && q.size() > 0) m_data = q[0].d;
        end
    end

    always @(negedge Clk) begin
        if (armed) begin
            chk("m_valid", 128'(out_valid), 128'(q.size() != 0));
            chk("m_ready", 128'(in_ready), 128'(q.size() < 2));
            chk("m_occ", 128'(occupancy), 128'(q.size()));
            chk("m_ctrl", 128'(out_ctrl),
                128'(q.size() != 0 ? q[0].c : 16'h0000));
            chk("m_data", 128'(out_data), 128'(m_data));
        end
    end

    task automatic step(input bit v, input logic [15:0] c, input bit r,
                        input bit f, input bit rst);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = mkd(c);
        out_ready = r;
        flush     = f;
        Reset     = rst;
        @(posedge Clk);
        #2;
    endtask

    initial begin
        step(0, 0, 0, 0, 1);
        chk("rst_valid", 128'(out_valid), 128'(0));
        chk("rst_occ", 128'(occupancy), 128'(0));
        chk("rst_ready", 128'(in_ready), 128'(1));
        chk("rst_ctrl", 128'(out_ctrl), 128'(0));
        chk("rst_data", 128'(out_data), 128'(0));

        for (int k = 1; k <= 5; k++) begin
            step(1, 16'(k), 1, 0, 0);
            chk("str_ctrl", 128'(out_ctrl), 128'(k));
            chk("str_occ", 128'(occupancy), 128'(1));
        end

        step(1, 16'd6, 0, 0, 0);
        chk("stl_occ", 128'(occupancy), 128'(2));
        chk("stl_ready", 128'(in_ready), 128'(0));
        chk("stl_ctrl", 128'(out_ctrl), 128'(5));
        step(1, 16'd7, 0, 0, 0);
        chk("stl_hold", 128'(out_ctrl), 128'(5));
        chk("stl_data", 128'(out_data), 128'(mkd(16'd5)));
        step(0, 0, 1, 0, 0);
        chk("rel_ctrl", 128'(out_ctrl), 128'(6));
        chk("rel_occ", 128'(occupancy), 128'(1));
        step(0, 0, 1, 0, 0);
        chk("drn_valid", 128'(out_valid), 128'(0));
        chk("drn_ctrl", 128'(out_ctrl), 128'(0));
        chk("drn_data", 128'(out_data),
            128'(96'hDEAD_0006_0123_4567_89AB_CDE9));

        step(1, 16'd8, 0, 0, 0);
        step(1, 16'd9, 0, 0, 0);
        chk("pre_fl_occ", 128'(occupancy), 128'(2));
        step(1, 16'd10, 0, 1, 0);
        chk("fl_valid", 128'(out_valid), 128'(0));
        chk("fl_ctrl", 128'(out_ctrl), 128'(0));
        chk("fl_occ", 128'(occupancy), 128'(0));
        chk("fl_ready", 128'(in_ready), 128'(1));
        step(1, 16'd11, 1, 1, 0);
        chk("fl_drop", 128'(occupancy), 128'(0));
        step(1, 16'd12, 1, 0, 0);
        chk("post_fl", 128'(out_ctrl), 128'(12));

        for (int k = 13; k <= 22; k++) begin
            step(1, 16'(k), 1, 0, 0);
            chk("pass_ctrl", 128'(out_ctrl), 128'(k));
            chk("pass_occ", 128'(occupancy), 128'(1));
        end

        step(1, 16'd23, 0, 0, 0);
        chk("pre_rst_occ", 128'(occupancy), 128'(2));
        step(0, 0, 0, 0, 1);
        chk("mrst_valid", 128'(out_valid), 128'(0));
        chk("mrst_data", 128'(out_data), 128'(0));
        chk("mrst_occ", 128'(occupancy), 128'(0));
        step(0, 0, 1, 0, 0);
        chk("mrst_gone", 128'(out_valid), 128'(0));

        for (int i = 0; i < 10000; i++) begin
            in_valid  = ($urandom_range(9) < 7);
            out_ready = (i % 400 < 200) ? ($urandom_range(9) < 6)
                                        : ($urandom_range(9) < 3);
            flush     = ($urandom_range(99) < 3);
            Reset     = ($urandom_range(199) == 0);
            in_ctrl   = 16'($urandom);
            in_data   = {$urandom, $urandom, $urandom};
            @(posedge Clk);
            #2;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
